// File: rtl/uart_ctl_pkg.sv
// uart_ctl_pkg: shared definitions for the UART transmit arbiter.
//   - FSM state encoding (state_t plus ST_* constants)
//   - HDR_MARK: upper nibble of the per-grant ID header byte
//   - clog2_min1(): ceil(log2(value)), never less than 1, for widths
// Optional feature macro referenced by users of this package:
//   UART_TX_ARB_ID_HEADER_EN (enables the ST_HDR state in the arbiter)
package uart_ctl_pkg;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SEL       = 3'd1;
    localparam logic [2:0] ST_START     = 3'd2;
    localparam logic [2:0] ST_WAIT_ACK  = 3'd3;
    localparam logic [2:0] ST_WAIT_DONE = 3'd4;
    localparam logic [2:0] ST_HDR       = 3'd5;

    // Header byte is HDR_MARK | grant_id; the low nibble holds the ID,
    // which limits the header scheme to 16 requesters.
    localparam logic [7:0] HDR_MARK = 8'hA0;

    function automatic int clog2_min1(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Finds the first set bit of req at or above ptr, wrapping modulo N.
// Ports:
//   req   in  [N-1:0]    request vector
//   ptr   in  [IDW-1:0]  round-robin start index (0..N-1)
//   found out            at least one request is set
//   idx   out [IDW-1:0]  selected index (0 when found=0)
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           found,
    output logic [IDW-1:0] idx
);

    logic [N-1:0]   mask;
    logic [2*N-1:0] dbl;

    // The low half holds only requests at or above ptr; the high half holds
    // the full vector. The lowest set bit of the concatenation is therefore
    // the first request at/after ptr, falling back to the wrapped-around one.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            mask[i] = (IDW'(i) >= ptr);
        end
        dbl = {req, req & mask};
    end

    // Scan from the top so the lowest set bit is the last assignment.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int j = 2 * N - 1; j >= 0; j--) begin
            if (dbl[j]) begin
                found = 1'b1;
                idx   = (j >= N) ? IDW'(j - N) : IDW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one 8N2 byte transmitter among NUM_REQ byte
// streams. Round-robin grants at packet granularity; a grant is released
// on the last byte of a packet or after MAX_BURST bytes (0 = unlimited).
// Each byte is sequenced as: tx_start pulse, wait busy high, wait busy low.
//
// Handshake: a requester byte transfers on the clk edge where
// req_valid[i] & req_ready[i] are both high. req_ready[i] is high only in
// SEL for the granted requester and does not look at req_valid.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   req_valid[i]    requester i has a byte
//   req_data        packed bytes, requester i on [8i+7:8i]
//   req_last[i]     byte is last of its packet
//   req_ready[i]    byte accepted (see handshake above)
//   tx_start        one-cycle start pulse, only while tx_busy=0
//   tx_data         byte for the transmitter, stable around tx_start
//   tx_busy         transmitter busy
//   grant_id        current (or most recent) owner
//   grant_active    a grant is held
//
// Optional feature macro: UART_TX_ARB_ID_HEADER_EN
//   When defined, every new grant first sends HDR_MARK | grant_id.
module uart_tx_arbiter
    import uart_ctl_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16,
    localparam int IDW      = clog2_min1(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 grant_active
);

    localparam int BW = clog2_min1(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_LIM = BW'(MAX_BURST);

    state_t         state_q,        state_d;
    logic [IDW-1:0] grant_id_q,     grant_id_d;
    logic           grant_active_q, grant_active_d;
    logic [IDW-1:0] rr_ptr_q,       rr_ptr_d;
    logic [BW-1:0]  burst_cnt_q,    burst_cnt_d;
    logic [7:0]     tx_data_q,      tx_data_d;
    logic           last_q,         last_d;
`ifdef UART_TX_ARB_ID_HEADER_EN
    // Marks that the byte in flight is the ID header, not payload.
    logic           hdr_q,          hdr_d;
`endif

    logic           pick_found;
    logic [IDW-1:0] pick_idx;
    logic           sel_valid;
    logic [7:0]     sel_data;
    logic           sel_last;
    logic [IDW-1:0] rr_next;
    logic           burst_done;

    rr_pick #(
        .N   (NUM_REQ),
        .IDW (IDW)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Mux the granted requester's inputs.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = 8'h00;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == IDW'(i)) begin
                sel_valid = req_valid[i];
                sel_data  = req_data[8*i +: 8];
                sel_last  = req_last[i];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == ST_SEL) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_id_q == IDW'(i)) begin
                    req_ready[i] = 1'b1;
                end
            end
        end
    end

    // Gating on tx_busy keeps us from restarting a transmitter that is
    // still finishing a frame, e.g. after a reset of this block alone.
    assign tx_start     = (state_q == ST_START) && !tx_busy;
    assign tx_data      = tx_data_q;
    assign grant_id     = grant_id_q;
    assign grant_active = grant_active_q;

    assign rr_next    = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + IDW'(1);
    assign burst_done = (MAX_BURST != 0) && (burst_cnt_q == BURST_LIM);

    always_comb begin
        state_d        = state_q;
        grant_id_d     = grant_id_q;
        grant_active_d = grant_active_q;
        rr_ptr_d       = rr_ptr_q;
        burst_cnt_d    = burst_cnt_q;
        tx_data_d      = tx_data_q;
        last_d         = last_q;
`ifdef UART_TX_ARB_ID_HEADER_EN
        hdr_d          = hdr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_id_d     = pick_idx;
                    grant_active_d = 1'b1;
                    burst_cnt_d    = '0;
`ifdef UART_TX_ARB_ID_HEADER_EN
                    state_d        = ST_HDR;
`else
                    state_d        = ST_SEL;
`endif
                end
            end
`ifdef UART_TX_ARB_ID_HEADER_EN
            ST_HDR: begin
                tx_data_d = HDR_MARK | 8'(grant_id_q);
                hdr_d     = 1'b1;
                state_d   = ST_START;
            end
`endif
            ST_SEL: begin
                if (sel_valid) begin
                    tx_data_d = sel_data;
                    last_d    = sel_last;
                    if (burst_cnt_q != BURST_LIM) begin
                        burst_cnt_d = burst_cnt_q + BW'(1);
                    end
`ifdef UART_TX_ARB_ID_HEADER_EN
                    hdr_d     = 1'b0;
`endif
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (!tx_busy) begin
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
`ifdef UART_TX_ARB_ID_HEADER_EN
                    if (hdr_q) begin
                        state_d = ST_SEL;
                    end else
`endif
                    if (last_q || burst_done) begin
                        rr_ptr_d       = rr_next;
                        grant_active_d = 1'b0;
                        state_d        = ST_IDLE;
                    end else begin
                        state_d = ST_SEL;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            grant_id_q     <= '0;
            grant_active_q <= 1'b0;
            rr_ptr_q       <= '0;
            burst_cnt_q    <= '0;
            tx_data_q      <= 8'h00;
            last_q         <= 1'b0;
`ifdef UART_TX_ARB_ID_HEADER_EN
            hdr_q          <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            grant_id_q     <= grant_id_d;
            grant_active_q <= grant_active_d;
            rr_ptr_q       <= rr_ptr_d;
            burst_cnt_q    <= burst_cnt_d;
            tx_data_q      <= tx_data_d;
            last_q         <= last_d;
`ifdef UART_TX_ARB_ID_HEADER_EN
            hdr_q          <= hdr_d;
`endif
        end
    end

endmodule
